// File: rtl/ml_stream_adapter.sv
// rtl/ml_stream_adapter.sv - packs stream beats into model vectors, tracks model latency, serializes results
module ml_stream_adapter #(
    parameter int IN_W      = 120,
    parameter int OUT_W     = 140,
    parameter int MODEL_LAT = 6,
    parameter int RES_DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [IN_W-1:0]  model_inp,
    input  logic [OUT_W-1:0] model_out,
    output logic [31:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic [2:0]       inflight,
    output logic [15:0]      vec_count
);
    localparam int IN_BEATS  = (IN_W + 31) / 32;
    localparam int OUT_BEATS = (OUT_W + 31) / 32;
    localparam int PACK_W    = 32 * (IN_BEATS - 1);
    localparam int TAIL_W    = IN_W - PACK_W;
    localparam int PC_W      = $clog2(IN_BEATS);
    localparam int BC_W      = $clog2(OUT_BEATS);
    localparam int PTR_W     = $clog2(RES_DEPTH);
    localparam int CNT_W     = 3;
    localparam int SUM_W     = CNT_W + 1;
    localparam logic [PC_W-1:0]  LAST_IN  = PC_W'(IN_BEATS - 1);
    localparam logic [BC_W-1:0]  LAST_OUT = BC_W'(OUT_BEATS - 1);
    localparam logic [SUM_W-1:0] CREDITS  = SUM_W'(RES_DEPTH);

    logic [PC_W-1:0]      pack_cnt_q, pack_cnt_d;
    logic [PACK_W-1:0]    pack_q, pack_d;
    logic [IN_W-1:0]      model_inp_q, model_inp_d;
    logic [MODEL_LAT:0]   tok_q, tok_d;
    logic [CNT_W-1:0]     inflight_q, inflight_d;
    logic [CNT_W-1:0]     buf_occ_q, buf_occ_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BC_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [15:0]          vec_count_q, vec_count_d;
    logic                 s_tready_q, s_tready_d;
    logic [OUT_W-1:0]     mem_q [RES_DEPTH];
    logic [32*OUT_BEATS-1:0] head_pad;
    logic [SUM_W-1:0]     credit_sum;
    logic                 s_hs, issue, capture, m_hs, pop;

    // A token reaching the top of the shift register marks a stable model_out
    always_comb begin
        s_hs    = s_tvalid & s_tready_q;
        issue   = s_hs && (pack_cnt_q == LAST_IN);
        capture = tok_q[MODEL_LAT];
        m_hs    = m_tvalid & m_tready;
        pop     = m_hs && (beat_cnt_q == LAST_OUT);

        pack_cnt_d  = pack_cnt_q;
        pack_d      = pack_q;
        model_inp_d = model_inp_q;
        if (s_hs) begin
            if (issue) begin
                pack_cnt_d  = '0;
                model_inp_d = {s_tdata[TAIL_W-1:0], pack_q};
            end else begin
                pack_cnt_d = pack_cnt_q + PC_W'(1);
                pack_d[{pack_cnt_q, 5'd0} +: 32] = s_tdata;
            end
        end

        tok_d       = {tok_q[MODEL_LAT-1:0], issue};
        inflight_d  = inflight_q + CNT_W'(issue) - CNT_W'(capture);
        buf_occ_d   = buf_occ_q + CNT_W'(capture) - CNT_W'(pop);
        wr_ptr_d    = capture ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        vec_count_d = pop ? vec_count_q + 16'd1 : vec_count_q;
        beat_cnt_d  = beat_cnt_q;
        if (m_hs) beat_cnt_d = pop ? '0 : beat_cnt_q + BC_W'(1);

        // Registered ready reflects the post-edge credit state, so a pop frees credit one cycle later
        credit_sum = {1'b0, inflight_d} + {1'b0, buf_occ_d};
        s_tready_d = (pack_cnt_d != LAST_IN) || (credit_sum < CREDITS);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pack_cnt_q  <= '0;
            pack_q      <= '0;
            model_inp_q <= '0;
            tok_q       <= '0;
            inflight_q  <= '0;
            buf_occ_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            vec_count_q <= '0;
            s_tready_q  <= 1'b0;
        end else begin
            pack_cnt_q  <= pack_cnt_d;
            pack_q      <= pack_d;
            model_inp_q <= model_inp_d;
            tok_q       <= tok_d;
            inflight_q  <= inflight_d;
            buf_occ_q   <= buf_occ_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            vec_count_q <= vec_count_d;
            s_tready_q  <= s_tready_d;
        end
    end

    // Result storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (capture) mem_q[wr_ptr_q] <= model_out;
    end

    always_comb begin
        head_pad = {{(32*OUT_BEATS-OUT_W){1'b0}}, mem_q[rd_ptr_q]};
        m_tvalid = (buf_occ_q != '0);
        m_tdata  = m_tvalid ? head_pad[{beat_cnt_q, 5'd0} +: 32] : 32'd0;
        m_tlast  = m_tvalid && (beat_cnt_q == LAST_OUT);
    end

    assign s_tready  = s_tready_q;
    assign model_inp = model_inp_q;
    assign inflight  = inflight_q;
    assign vec_count = vec_count_q;
endmodule

// File: tb/tb_ml_stream_adapter.sv
// tb/tb_ml_stream_adapter.sv - randomized self-checking bench for ml_stream_adapter
module tb_ml_stream_adapter;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  s_tdata = 32'd0;
    logic         s_tvalid = 1'b0;
    logic         s_tready;
    logic [119:0] model_inp;
    logic [139:0] model_out;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b0;
    logic         m_tlast;
    logic [2:0]   inflight;
    logic [15:0]  vec_count;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int in_acc_cnt = 0;
    int max_inflight = 0;
    int stall_viol = 0;
    bit s_acc_pending = 1'b0;
    bit prev_stall = 1'b0;
    logic [32:0] prev_beat;
    logic [31:0] tx_q[$];
    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    logic [119:0] pipe [6];

    ml_stream_adapter dut (
        .clk(clk), .resetn(resetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .model_inp(model_inp), .model_out(model_out),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .inflight(inflight), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    // Model stub: six register stages, result = {20'hABCDE, input}
    always @(posedge clk) begin
        pipe[0] <= model_inp;
        for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
    end
    assign model_out = {20'hABCDE, pipe[5]};

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Drivers: input beats from tx_q, m_tready per rdy_mode
    initial forever begin
        @(posedge clk);
        #1;
        if (!resetn) begin
            s_acc_pending = 1'b0;
            s_tvalid = 1'b0;
            s_tdata = 32'd0;
        end else begin
            if (s_acc_pending && tx_q.size() > 0) void'(tx_q.pop_front());
            s_acc_pending = 1'b0;
            s_tvalid = (tx_q.size() > 0);
            s_tdata = s_tvalid ? tx_q[0] : 32'd0;
        end
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'b0;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: records handshakes and stall stability
    initial forever begin
        @(negedge clk);
        if (resetn) begin
            if (s_tvalid && s_tready) begin
                s_acc_pending = 1'b1;
                in_acc_cnt++;
            end
            if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
            if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
            if (prev_stall && (!m_tvalid || {m_tlast, m_tdata} !== prev_beat)) stall_viol++;
            prev_stall = m_tvalid && !m_tready;
            prev_beat = {m_tlast, m_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic rand_vec(output logic [119:0] v);
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        v = r[119:0];
    endtask

    // Reference: result is {20'hABCDE, vector}, split into 32-bit beats, zero padded at the top
    task automatic push_vec(input logic [119:0] v);
        logic [159:0] pad;
        logic [7:0] junk;
        junk = 8'($urandom_range(0, 255));
        pad = {20'h0, 20'hABCDE, v};
        tx_q.push_back(v[31:0]);
        tx_q.push_back(v[63:32]);
        tx_q.push_back(v[95:64]);
        tx_q.push_back({junk, v[119:96]});
        for (int j = 0; j < 5; j++) exp_q.push_back({(j == 4), pad[32*j +: 32]});
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        tx_q.delete();
        exp_q.delete();
        obs_q.delete();
        repeat (3) @(posedge clk);
        #3;
        resetn = 1'b1;
        in_acc_cnt = 0;
        max_inflight = 0;
        stall_viol = 0;
        @(posedge clk);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (tx_q.size() == 0 && obs_q.size() >= exp_q.size() && !m_tvalid && inflight == 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tready: got %b expected 0", s_tready); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
        n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_m_tlast: got %b expected 0", m_tlast); end
        n_checks++; if (m_tdata !== 32'd0) begin n_fail++; $display("FAIL reset_m_tdata: got %h expected 0", m_tdata); end
        n_checks++; if (model_inp !== 120'd0) begin n_fail++; $display("FAIL reset_model_inp: got %h expected 0", model_inp); end
        n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
        n_checks++; if (vec_count !== 16'd0) begin n_fail++; $display("FAIL reset_vec_count: got %0d expected 0", vec_count); end
        #2;
        resetn = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_single();
        int acc, e0, first;
        bit ok;
        logic [32:0] expv [5];
        expv[0] = {1'b0, 32'h11111111};
        expv[1] = {1'b0, 32'h22222222};
        expv[2] = {1'b0, 32'h33333333};
        expv[3] = {1'b0, 32'hDE444444};
        expv[4] = {1'b1, 32'h00000ABC};
        rdy_mode = 0;
        obs_q.delete();
        tx_q.push_back(32'h11111111);
        tx_q.push_back(32'h22222222);
        tx_q.push_back(32'h33333333);
        tx_q.push_back(32'hFF444444);
        acc = 0; e0 = -1; first = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_tvalid && s_tready) begin
                acc++;
                if (acc == 4) e0 = cyc + 1;
            end
            if (m_tvalid && first < 0) first = cyc;
        end
        wait_drain(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_drain: got timeout expected drained"); end
        n_checks++; if (first - e0 !== 7) begin n_fail++; $display("FAIL single_latency: got %0d expected 7", first - e0); end
        n_checks++; if (model_inp !== 120'h444444_33333333_22222222_11111111) begin n_fail++; $display("FAIL single_model_inp: got %h expected 444444333333332222222211111111", model_inp); end
        n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL single_beat_count: got %0d expected 5", obs_q.size()); end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== expv[i]) begin n_fail++; $display("FAIL single_beat[%0d]: got %h expected %h", i, obs_q[i], expv[i]); end
        end
        n_checks++; if (vec_count !== 16'd1) begin n_fail++; $display("FAIL single_vec_count: got %0d expected 1", vec_count); end
    endtask

    task automatic test_back_to_back();
        logic [119:0] v;
        bit ok;
        apply_reset();
        rdy_mode = 0;
        for (int k = 0; k < 8; k++) begin rand_vec(v); push_vec(v); end
        wait_drain(400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_drain: got timeout expected drained"); end
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (max_inflight > 4) begin n_fail++; $display("FAIL b2b_max_inflight: got %0d expected <=4", max_inflight); end
        n_checks++; if (in_acc_cnt !== 32) begin n_fail++; $display("FAIL b2b_in_beats: got %0d expected 32", in_acc_cnt); end
        n_checks++; if (vec_count !== 16'd8) begin n_fail++; $display("FAIL b2b_vec_count: got %0d expected 8", vec_count); end
    endtask

    task automatic test_backpressure();
        logic [119:0] v;
        apply_reset();
        rdy_mode = 1;
        for (int k = 0; k < 5; k++) begin rand_vec(v); push_vec(v); end
        repeat (60) @(posedge clk);
        #2;
        n_checks++; if (in_acc_cnt !== 19) begin n_fail++; $display("FAIL bp_in_beats: got %0d expected 19", in_acc_cnt); end
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL bp_s_tready: got %b expected 0", s_tready); end
        n_checks++; if (s_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_s_tvalid: got %b expected 1", s_tvalid); end
        n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL bp_inflight: got %0d expected 0", inflight); end
        n_checks++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_m_tvalid: got %b expected 1", m_tvalid); end
        n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL bp_no_output: got %0d expected 0", obs_q.size()); end
        n_checks++; if (max_inflight > 4) begin n_fail++; $display("FAIL bp_max_inflight: got %0d expected <=4", max_inflight); end
    endtask

    task automatic test_credit_timing();
        bit found, ok;
        found = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (m_tvalid && m_tready && m_tlast) begin
                found = 1'b1;
                n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL credit_pop_cycle: got s_tready=%b expected 0", s_tready); end
                @(negedge clk);
                n_checks++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL credit_next_cycle: got s_tready=%b expected 1", s_tready); end
            end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL credit_pop_seen: got timeout expected pop"); end
        wait_drain(300, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL credit_drain: got timeout expected drained"); end
        n_checks++; if (obs_q.size() !== 25) begin n_fail++; $display("FAIL credit_beat_count: got %0d expected 25", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL credit_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (vec_count !== 16'd5) begin n_fail++; $display("FAIL credit_vec_count: got %0d expected 5", vec_count); end
    endtask

    task automatic test_random_stall();
        logic [119:0] v;
        bit ok;
        apply_reset();
        rdy_mode = 2;
        for (int k = 0; k < 6; k++) begin rand_vec(v); push_vec(v); end
        wait_drain(1500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_drain: got timeout expected drained"); end
        n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stall_beat_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_stability: got %0d changes expected 0", stall_viol); end
        n_checks++; if (vec_count !== 16'd6) begin n_fail++; $display("FAIL stall_vec_count: got %0d expected 6", vec_count); end
    endtask

    task automatic test_reset_mid();
        logic [119:0] v;
        bit ok, seen;
        apply_reset();
        rdy_mode = 0;
        rand_vec(v); push_vec(v);
        rand_vec(v); push_vec(v);
        tx_q.push_back($urandom());
        tx_q.push_back($urandom());
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            if (obs_q.size() >= 2) seen = 1'b1;
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_serializing: got timeout expected 2 beats out"); end
        #3;
        n_checks++; if (inflight !== 3'd1) begin n_fail++; $display("FAIL mid_pre_inflight: got %0d expected 1", inflight); end
        resetn = 1'b0;
        #1;
        n_checks++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL mid_s_tready: got %b expected 0", s_tready); end
        n_checks++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_m_tvalid: got %b expected 0", m_tvalid); end
        n_checks++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL mid_m_tlast: got %b expected 0", m_tlast); end
        n_checks++; if (m_tdata !== 32'd0) begin n_fail++; $display("FAIL mid_m_tdata: got %h expected 0", m_tdata); end
        n_checks++; if (model_inp !== 120'd0) begin n_fail++; $display("FAIL mid_model_inp: got %h expected 0", model_inp); end
        n_checks++; if (inflight !== 3'd0) begin n_fail++; $display("FAIL mid_inflight: got %0d expected 0", inflight); end
        n_checks++; if (vec_count !== 16'd0) begin n_fail++; $display("FAIL mid_vec_count: got %0d expected 0", vec_count); end
        tx_q.delete();
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(posedge clk);
        #4;
        resetn = 1'b1;
        @(posedge clk);
        rand_vec(v); push_vec(v);
        wait_drain(100, ok);
        repeat (20) @(posedge clk);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_drain: got timeout expected drained"); end
        n_checks++; if (obs_q.size() !== 5) begin n_fail++; $display("FAIL mid_beat_count: got %0d expected 5", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_beat[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (vec_count !== 16'd1) begin n_fail++; $display("FAIL mid_post_vec_count: got %0d expected 1", vec_count); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_credit_timing();
        test_random_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
